// File: rtl/escalonador_chamadas.sv
// ---------------------------------------------------------------------------
// escalonador_chamadas
//
// Call scheduler for a four-floor elevator. It latches floor calls, picks a
// travel direction, asks the floor controller for one floor step at a time,
// opens the door at served floors and flags a fault when a requested step
// never completes.
//
// State table
//   state   | meaning
//   --------+---------------------------------------------------------------
//   OCIOSO  | idle, deciding: serve the current floor in place or start a step
//   PEDIR   | one-cycle step request (o_mover=1), origin floor latched
//   AGUARDA | waiting for the floor controller to report a new floor
//   PORTA   | door open, door counter running down on i_tick
//   ERRO    | step timed out; held until reset
//
// Parameters
//   TEMPO_PORTA : ticks the door stays open per stop (1..15)
//   LIMITE_MOV  : ticks allowed for a requested step before fault (1..15)
//
// Ports
//   i_clock_in      sole clock, rising edge
//   i_reset         synchronous, active-high reset
//   i_tick          one-cycle pacing enable for the door and timeout counters
//   i_chamada[3:0]  level-sensitive floor call buttons, bit i = floor i
//   i_andar_atual   current floor from the floor controller (0..3)
//   o_mover         one-cycle request for exactly one floor step
//   o_sentido       step direction, 1 = up, 0 = down; held between steps
//   o_porta_aberta  door open
//   o_pendentes     latched, unserviced calls
//   o_ocupado       high whenever the scheduler is not idle
//   o_erro          movement-timeout fault
//
// All outputs are registered; they are computed from the next state so they
// line up with the state register.
// ---------------------------------------------------------------------------
module escalonador_chamadas #(
    parameter int TEMPO_PORTA = 3,
    parameter int LIMITE_MOV  = 8
) (
    input  logic       i_clock_in,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic [3:0] i_chamada,
    input  logic [1:0] i_andar_atual,
    output logic       o_mover,
    output logic       o_sentido,
    output logic       o_porta_aberta,
    output logic [3:0] o_pendentes,
    output logic       o_ocupado,
    output logic       o_erro
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        PEDIR   = 3'd1,
        AGUARDA = 3'd2,
        PORTA   = 3'd3,
        ERRO    = 3'd4
    } estado_t;

    localparam logic [3:0] C_TEMPO  = 4'(TEMPO_PORTA);
    localparam logic [3:0] C_LIMITE = 4'(LIMITE_MOV);

    estado_t    r_estado;
    logic [3:0] r_cont_porta;
    logic [3:0] r_cont_mov;
    logic [1:0] r_origem;
    logic       r_sentido;
    logic [3:0] r_pendentes;
    logic       r_mover;
    logic       r_porta;
    logic       r_ocupado;
    logic       r_erro;

    estado_t    w_estado_prox;
    logic [3:0] w_cont_porta_prox;
    logic [3:0] w_cont_mov_prox;
    logic [1:0] w_origem_prox;
    logic       w_sentido_prox;
    logic [3:0] w_pendentes_prox;
    logic [3:0] w_andar_oh;
    logic [3:0] w_mascara;
    logic [3:0] w_cont_mov_inc;
    logic       w_acima;
    logic       w_abaixo;
    logic       w_dir;
    logic       w_servir_aqui;

    // Pending-call geometry relative to the current floor.
    always_comb begin
        w_andar_oh = 4'b0001 << i_andar_atual;
        w_acima    = 1'b0;
        w_abaixo   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r_pendentes[i]) begin
                if (2'(i) > i_andar_atual) w_acima  = 1'b1;
                if (2'(i) < i_andar_atual) w_abaixo = 1'b1;
            end
        end
        // Keep going the current way while something lies ahead, else turn.
        // At floor 3 nothing is above and at floor 0 nothing is below, so the
        // choice can never point off the shaft.
        w_dir = r_sentido ? w_acima : ~w_abaixo;
    end

    // Saturating timeout increment.
    always_comb begin
        w_cont_mov_inc = (r_cont_mov == 4'hF) ? 4'hF : r_cont_mov + 4'd1;
    end

    // Calls at the floor the car is parked at (idle or door open) are served
    // in place and never latched.
    always_comb begin
        w_mascara = ((r_estado == OCIOSO) || (r_estado == PORTA)) ? w_andar_oh : 4'b0000;
        // A call latched for this floor while the car was still here (during
        // the request cycle) is also served in place rather than stepping away.
        w_servir_aqui = i_chamada[i_andar_atual] | r_pendentes[i_andar_atual];
    end

    always_comb begin
        w_estado_prox     = r_estado;
        w_cont_porta_prox = r_cont_porta;
        w_cont_mov_prox   = r_cont_mov;
        w_origem_prox     = r_origem;
        w_sentido_prox    = r_sentido;
        w_pendentes_prox  = r_pendentes | (i_chamada & ~w_mascara);

        case (r_estado)
            OCIOSO: begin
                if (w_servir_aqui) begin
                    w_estado_prox     = PORTA;
                    w_cont_porta_prox = C_TEMPO;
                    w_pendentes_prox  = w_pendentes_prox & ~w_andar_oh;
                end else if (r_pendentes != 4'b0000) begin
                    w_estado_prox   = PEDIR;
                    w_sentido_prox  = w_dir;
                    w_origem_prox   = i_andar_atual;
                    w_cont_mov_prox = 4'd0;
                end
            end

            PEDIR: begin
                w_estado_prox = AGUARDA;
            end

            AGUARDA: begin
                // A floor change beats a timeout reached on the same edge.
                if (i_andar_atual != r_origem) begin
                    if (r_pendentes[i_andar_atual] || i_chamada[i_andar_atual]) begin
                        w_estado_prox     = PORTA;
                        w_cont_porta_prox = C_TEMPO;
                        // Clearing beats a call arriving on the same edge.
                        w_pendentes_prox  = w_pendentes_prox & ~w_andar_oh;
                    end else begin
                        w_estado_prox = OCIOSO;
                    end
                end else if (i_tick) begin
                    w_cont_mov_prox = w_cont_mov_inc;
                    if (w_cont_mov_inc >= C_LIMITE) begin
                        w_estado_prox = ERRO;
                    end
                end
            end

            PORTA: begin
                if (i_chamada[i_andar_atual]) begin
                    w_cont_porta_prox = C_TEMPO;
                end else if (i_tick) begin
                    if (r_cont_porta <= 4'd1) begin
                        w_cont_porta_prox = 4'd0;
                        w_estado_prox     = OCIOSO;
                    end else begin
                        w_cont_porta_prox = r_cont_porta - 4'd1;
                    end
                end
            end

            ERRO: begin
                w_estado_prox = ERRO;
            end

            default: begin
                w_estado_prox = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge i_clock_in) begin
        if (i_reset) begin
            r_estado     <= OCIOSO;
            r_cont_porta <= 4'd0;
            r_cont_mov   <= 4'd0;
            r_origem     <= 2'd0;
            r_sentido    <= 1'b1;
            r_pendentes  <= 4'b0000;
            r_mover      <= 1'b0;
            r_porta      <= 1'b0;
            r_ocupado    <= 1'b0;
            r_erro       <= 1'b0;
        end else begin
            r_estado     <= w_estado_prox;
            r_cont_porta <= w_cont_porta_prox;
            r_cont_mov   <= w_cont_mov_prox;
            r_origem     <= w_origem_prox;
            r_sentido    <= w_sentido_prox;
            r_pendentes  <= w_pendentes_prox;
            r_mover      <= (w_estado_prox == PEDIR);
            r_porta      <= (w_estado_prox == PORTA);
            r_ocupado    <= (w_estado_prox != OCIOSO);
            r_erro       <= (w_estado_prox == ERRO);
        end
    end

    assign o_mover        = r_mover;
    assign o_sentido      = r_sentido;
    assign o_porta_aberta = r_porta;
    assign o_pendentes    = r_pendentes;
    assign o_ocupado      = r_ocupado;
    assign o_erro         = r_erro;

endmodule

// File: tb/tb_escalonador_chamadas.sv
module tb_escalonador_chamadas;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_tick;
    logic [3:0] i_chamada;
    logic [1:0] i_andar;
    logic       o_mover;
    logic       o_sentido;
    logic       o_porta_aberta;
    logic [3:0] o_pendentes;
    logic       o_ocupado;
    logic       o_erro;

    int   checks   = 0;
    int   failures = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    escalonador_chamadas #(.TEMPO_PORTA(3), .LIMITE_MOV(8)) dut (
        .i_clock_in    (clk),
        .i_reset       (i_reset),
        .i_tick        (i_tick),
        .i_chamada     (i_chamada),
        .i_andar_atual (i_andar),
        .o_mover       (o_mover),
        .o_sentido     (o_sentido),
        .o_porta_aberta(o_porta_aberta),
        .o_pendentes   (o_pendentes),
        .o_ocupado     (o_ocupado),
        .o_erro        (o_erro)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
    endtask

    task automatic call_pulse(input logic [3:0] c);
        i_chamada = c;
        step();
        i_chamada = 4'b0000;
    endtask

    // Reset with every call button pressed: the calls must be ignored.
    task automatic do_reset(input logic [1:0] andar);
        i_reset   = 1'b1;
        i_andar   = andar;
        i_chamada = 4'b1111;
        step();
        i_chamada = 4'b0000;
        i_reset   = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_mover"},    4'(o_mover),        4'd0);
        chk({tag, "_sentido"},  4'(o_sentido),      4'd1);
        chk({tag, "_porta"},    4'(o_porta_aberta), 4'd0);
        chk({tag, "_pend"},     o_pendentes,        4'b0000);
        chk({tag, "_ocupado"},  4'(o_ocupado),      4'd0);
        chk({tag, "_erro"},     4'(o_erro),         4'd0);
    endtask

    // Waits for a step request, compares its direction with the scoreboard,
    // optionally moves the car one floor, and checks the request is one cycle.
    task automatic serve_step(input string tag, input bit do_move);
        bit   found;
        logic expd;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (o_mover === 1'b1) found = 1'b1;
        end
        chk({tag, "_mover_seen"}, 4'(found), 4'd1);
        if (found) begin
            chk({tag, "_sb_nonempty"}, 4'(exp_q.size() != 0), 4'd1);
            expd = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
            chk({tag, "_sentido"}, 4'(o_sentido), 4'(expd));
            if (do_move) i_andar = expd ? i_andar + 2'd1 : i_andar - 2'd1;
            step();
            chk({tag, "_mover_pulse"}, 4'(o_mover), 4'd0);
        end
    endtask

    task automatic wait_porta(input string tag);
        bit found;
        found = (o_porta_aberta === 1'b1);
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (o_porta_aberta === 1'b1) found = 1'b1;
        end
        chk({tag, "_porta_open"}, 4'(found), 4'd1);
    endtask

    task automatic door_ticks(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            pulse_tick();
            chk({tag, "_door_tick"}, 4'(o_porta_aberta), 4'(k < n));
        end
    endtask

    initial begin
        bit seen;
        i_reset   = 1'b1;
        i_tick    = 1'b0;
        i_chamada = 4'b0000;
        i_andar   = 2'd0;
        step();
        step();
        i_reset = 1'b0;
        check_reset("rst0");

        // Call to floor 3 from floor 0: three up steps, stop, door 3 ticks.
        call_pulse(4'b1000);
        chk("t1_pend_latch", o_pendentes, 4'b1000);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        serve_step("t1_s1", 1'b1);
        serve_step("t1_s2", 1'b1);
        serve_step("t1_s3", 1'b1);
        wait_porta("t1");
        chk("t1_floor", 4'(i_andar), 4'd3);
        chk("t1_pend_clear", o_pendentes, 4'b0000);
        door_ticks("t1", 3);
        chk("t1_idle", 4'(o_ocupado), 4'd0);

        // Floor 1 heading up with calls at 3 and 0: serve 3 first, then 0.
        do_reset(2'd1);
        check_reset("rst1");
        call_pulse(4'b1001);
        chk("t2_pend_latch", o_pendentes, 4'b1001);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        serve_step("t2_up1", 1'b1);
        serve_step("t2_up2", 1'b1);
        wait_porta("t2_at3");
        chk("t2_pend_after3", o_pendentes, 4'b0001);
        door_ticks("t2_at3", 3);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        serve_step("t2_dn1", 1'b1);
        serve_step("t2_dn2", 1'b1);
        serve_step("t2_dn3", 1'b1);
        wait_porta("t2_at0");
        chk("t2_pend_after0", o_pendentes, 4'b0000);
        door_ticks("t2_at0", 3);

        // Call at the idle floor: door opens at once, held while pressed.
        do_reset(2'd2);
        i_chamada = 4'b0100;
        step();
        chk("t3_porta_now", 4'(o_porta_aberta), 4'd1);
        chk("t3_pend_none", o_pendentes, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            pulse_tick();
            chk("t3_hold", 4'(o_porta_aberta), 4'd1);
        end
        i_chamada = 4'b0000;
        door_ticks("t3_release", 3);
        chk("t3_pend_end", o_pendentes, 4'b0000);

        // Floor frozen after a step request: fault on the 8th tick.
        do_reset(2'd0);
        call_pulse(4'b0010);
        exp_q.push_back(1'b1);
        serve_step("t4", 1'b0);
        for (int k = 1; k <= 7; k++) begin
            pulse_tick();
            chk("t4_no_err_yet", 4'(o_erro), 4'd0);
        end
        pulse_tick();
        chk("t4_erro", 4'(o_erro), 4'd1);
        chk("t4_ocupado", 4'(o_ocupado), 4'd1);
        chk("t4_porta", 4'(o_porta_aberta), 4'd0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) i_tick = 1'b1;
            if (k == 4) i_tick = 1'b0;
            step();
            if (o_mover !== 1'b0) seen = 1'b1;
        end
        chk("t4_no_mover", 4'(seen), 4'd0);
        chk("t4_erro_held", 4'(o_erro), 4'd1);
        do_reset(2'd0);
        check_reset("rst4");

        // Floor change on the same edge as the 8th tick, call also pressed.
        call_pulse(4'b0010);
        exp_q.push_back(1'b1);
        serve_step("t5", 1'b0);
        for (int k = 1; k <= 7; k++) pulse_tick();
        i_andar   = 2'd1;
        i_chamada = 4'b0010;
        i_tick    = 1'b1;
        step();
        i_tick    = 1'b0;
        i_chamada = 4'b0000;
        chk("t5_no_erro", 4'(o_erro), 4'd0);
        chk("t5_porta", 4'(o_porta_aberta), 4'd1);
        chk("t5_pend", o_pendentes, 4'b0000);
        door_ticks("t5", 3);

        // Reset while waiting for a step with calls pending.
        do_reset(2'd0);
        call_pulse(4'b0110);
        chk("t6_pend_latch", o_pendentes, 4'b0110);
        exp_q.push_back(1'b1);
        serve_step("t6", 1'b0);
        chk("t6_busy", 4'(o_ocupado), 4'd1);
        do_reset(2'd0);
        check_reset("rst6");

        chk("sb_drained", 4'(exp_q.size() == 0), 4'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/escalonador_chamadas.md
ESCALONADOR_CHAMADAS -- requirements
Module: escalonador_chamadas

Interface
REQ-001 TEMPO_PORTA, default 3, ticks the door stays open per stop (1..15).
REQ-002 LIMITE_MOV, default 8, ticks allowed for a requested step to complete before fault (1..15).
REQ-003 clock_in  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  one-cycle enable from the frequency divider; paces door and timeout counters only.
REQ-006 chamada  input  4  floor call buttons, level-sensitive; bit i = call at floor i.
REQ-007 andar_atual  input  2  current floor reported by the floor controller (0..3).
REQ-008 mover  output  1  one-cycle pulse requesting exactly one floor step.
REQ-009 sentido  output  1  step direction, 1 = up, 0 = down; valid with mover, held between steps.
REQ-010 porta_aberta  output  1  door-open indication.
REQ-011 pendentes  output  4  latched, unserviced calls.
REQ-012 ocupado  output  1  high whenever state is not OCIOSO.
REQ-013 erro  output  1  movement-timeout fault flag.

Function
REQ-014 States SHALL be OCIOSO, PEDIR, AGUARDA, PORTA, ERRO; all outputs registered.
REQ-015 pendentes[i] SHALL set on any edge with chamada[i]=1, except i==andar_atual while in OCIOSO or PORTA (serviced in place, never latched).
REQ-016 OCIOSO: chamada[andar_atual]=1 -> PORTA, door counter loaded with TEMPO_PORTA.
REQ-017 OCIOSO: else if pendentes!=0 -> PEDIR with direction chosen per REQ-018; else stay.
REQ-018 Direction: keep current sentido if any pending floor lies in that direction, else reverse; sentido=1 never issued at floor 3, sentido=0 never at floor 0.
REQ-019 PEDIR: mover=1 for exactly one cycle; origin floor latched; timeout counter cleared; next state AGUARDA.
REQ-020 AGUARDA: mover=0; on andar_atual != origin, if pendentes[andar_atual]=1 -> clear that bit, PORTA, door counter=TEMPO_PORTA; else -> OCIOSO (re-decides next cycle).
REQ-021 AGUARDA: timeout counter increments per tick; reaching LIMITE_MOV with no floor change -> ERRO.
REQ-022 Floor change and timeout limit on the same edge: floor change wins.
REQ-023 PORTA: porta_aberta=1; counter decrements per tick; at 0 -> OCIOSO, porta_aberta=0 next cycle.
REQ-024 PORTA: chamada[andar_atual]=1 reloads counter to TEMPO_PORTA (door hold).
REQ-025 Arrival at floor i with chamada[i]=1 same edge: clear wins, pendentes[i]=0.
REQ-026 ERRO: erro=1, mover=0, porta_aberta=0, pendentes keep latching; exit only by reset.
REQ-027 Counters 4-bit, saturate, never wrap.

Reset
REQ-028 reset=1 SHALL force, next edge: OCIOSO, mover=0, sentido=1, porta_aberta=0, pendentes=0000, ocupado=0, erro=0, counters 0.
REQ-029 reset SHALL override every state, including mid-step (AGUARDA) and door open (PORTA); chamada ignored that cycle.

Verification
REQ-030 andar_atual=0, chamada=1000 pulse -> pendentes=1000, mover pulse sentido=1; bench steps floor 0->1->2->3 each after one mover pulse -> stop at 3, pendentes=0000, porta_aberta=1 for 3 ticks.
REQ-031 At floor 1 moving up, pendentes=1001 -> serves floor 3 first, then reverses, sentido=0, serves floor 0.
REQ-032 Idle at floor 2, chamada=0100 -> PORTA immediately, pendentes stays 0000; holding chamada=0100 keeps porta_aberta=1 until released + 3 ticks.
REQ-033 mover issued, andar_atual frozen for 8 ticks -> erro=1, ocupado=1, no further mover; reset -> all outputs per REQ-028.
REQ-034 Floor change on the same edge as 8th timeout tick -> no erro, normal arrival.
REQ-035 reset asserted in AGUARDA with pendentes=0110 -> next cycle pendentes=0000, sentido=1, OCIOSO.
